// File: rtl/pwm_duty_ramp.sv
// Duty-cycle slew limiter: accepts a duty target over valid/ready and walks the
// 7-bit duty output toward it by STEP percent every DIV clocks, clamped to MAX_DUTY.
module pwm_duty_ramp #(
    parameter int unsigned STEP     = 1,
    parameter int unsigned DIV      = 1000,
    parameter int unsigned MAX_DUTY = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] tgt_in,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    output logic [6:0] duty,
    output logic       busy,
    output logic       done,
    output logic       clamp_err
);

    localparam int unsigned DW = 7;
    localparam int unsigned PW = 16;
    localparam logic [DW:0]   C_STEP = 8'(STEP);
    localparam logic [DW:0]   C_MAX  = 8'(MAX_DUTY);
    localparam logic [PW-1:0] C_LAST = 16'(DIV - 1);

    typedef enum logic {S_IDLE = 1'b0, S_RAMP = 1'b1} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_duty;
    logic [DW-1:0]   r_tgt;
    logic [PW-1:0]   r_psc;
    logic            r_busy;
    logic            r_done;
    logic            r_clamp;

    state_t          w_state_nxt;
    logic [DW-1:0]   w_duty_nxt;
    logic [DW-1:0]   w_tgt_nxt;
    logic [PW-1:0]   w_psc_nxt;
    logic            w_done_nxt;
    logic            w_clamp_nxt;

    logic            w_over;
    logic [DW-1:0]   w_tgt_clamped;
    logic            w_step_edge;
    logic            w_up;
    logic [DW:0]     w_diff_up;
    logic [DW:0]     w_diff_dn;
    logic [DW-1:0]   w_step_duty;
    logic            w_landed;

    assign tgt_ready = enable & reset;

    assign w_over        = {1'b0, tgt_in} > C_MAX;
    assign w_tgt_clamped = w_over ? 7'(C_MAX) : tgt_in;

    // Step arithmetic is done one bit wider so a step can never wrap past 0 or 127.
    assign w_step_edge = (r_state == S_RAMP) && (r_psc == C_LAST);
    assign w_up        = r_tgt > r_duty;
    assign w_diff_up   = {1'b0, r_tgt} - {1'b0, r_duty};
    assign w_diff_dn   = {1'b0, r_duty} - {1'b0, r_tgt};

    always_comb begin
        w_step_duty = r_duty;
        if (w_up) begin
            w_step_duty = (w_diff_up <= C_STEP) ? r_tgt : 7'({1'b0, r_duty} + C_STEP);
        end else begin
            w_step_duty = (w_diff_dn <= C_STEP) ? r_tgt : 7'({1'b0, r_duty} - C_STEP);
        end
    end

    assign w_landed = (w_step_duty == r_tgt);

    // State register plus the registered datapath it steers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_psc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_clamp <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_tgt   <= w_tgt_nxt;
            r_psc   <= w_psc_nxt;
            r_busy  <= (w_state_nxt == S_RAMP);
            r_done  <= w_done_nxt;
            r_clamp <= w_clamp_nxt;
        end
    end

    // Next state: acceptance outranks a coincident step.
    always_comb begin
        w_state_nxt = r_state;
        if (enable) begin
            if (tgt_valid) begin
                w_state_nxt = (w_tgt_clamped != r_duty) ? S_RAMP : S_IDLE;
            end else if (w_step_edge && w_landed) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // Next datapath values; with enable low everything holds and pulses stay low.
    always_comb begin
        w_duty_nxt  = r_duty;
        w_tgt_nxt   = r_tgt;
        w_psc_nxt   = r_psc;
        w_done_nxt  = 1'b0;
        w_clamp_nxt = 1'b0;
        if (enable) begin
            if (tgt_valid) begin
                w_tgt_nxt   = w_tgt_clamped;
                w_clamp_nxt = w_over;
                w_psc_nxt   = '0;
                w_done_nxt  = (w_tgt_clamped == r_duty);
            end else if (r_state == S_RAMP) begin
                if (w_step_edge) begin
                    w_psc_nxt  = '0;
                    w_duty_nxt = w_step_duty;
                    w_done_nxt = w_landed;
                end else begin
                    w_psc_nxt = r_psc + 16'd1;
                end
            end
        end
    end

    assign duty      = r_duty;
    assign busy      = r_busy;
    assign done      = r_done;
    assign clamp_err = r_clamp;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: a cycle-indexed reference model queues the
// expected outputs for every edge and a negedge monitor compares them to the DUT.
module tb_pwm_duty_ramp;

    localparam int STEP     = 5;
    localparam int DIV      = 4;
    localparam int MAX_DUTY = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] tgt_in;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [6:0] duty;
    logic       busy;
    logic       done;
    logic       clamp_err;

    always #5 clk = ~clk;

    pwm_duty_ramp #(
        .STEP     (STEP),
        .DIV      (DIV),
        .MAX_DUTY (MAX_DUTY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .tgt_in    (tgt_in),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .duty      (duty),
        .busy      (busy),
        .done      (done),
        .clamp_err (clamp_err)
    );

    typedef struct {
        int duty;
        bit busy;
        bit done;
        bit clamp;
        bit rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the next step is scheduled as an absolute edge number,
    // pushed back one edge for every edge spent with enable low.
    int   n      = 0;
    int   m_duty = 0;
    int   m_tgt  = 0;
    int   m_next = 0;
    bit   m_ramp = 0;
    bit   m_done = 0;
    bit   m_clamp = 0;

    function automatic void model_edge(bit r, bit e, bit v, int t);
        m_done  = 0;
        m_clamp = 0;
        if (!r) begin
            m_duty = 0;
            m_tgt  = 0;
            m_ramp = 0;
        end else if (!e) begin
            if (m_ramp) m_next = m_next + 1;
        end else if (v) begin
            m_tgt   = (t > MAX_DUTY) ? MAX_DUTY : t;
            m_clamp = (t > MAX_DUTY);
            if (m_tgt != m_duty) begin
                m_ramp = 1;
                m_next = n + DIV;
            end else begin
                m_ramp = 0;
                m_done = 1;
            end
        end else if (m_ramp && n == m_next) begin
            if (m_tgt > m_duty)
                m_duty = (m_duty + STEP > m_tgt) ? m_tgt : m_duty + STEP;
            else
                m_duty = (m_duty - STEP < m_tgt) ? m_tgt : m_duty - STEP;
            if (m_duty == m_tgt) begin
                m_ramp = 0;
                m_done = 1;
            end else begin
                m_next = n + DIV;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, queue the model's prediction.
    task automatic drive(input bit r, input bit e, input bit v, input int t);
        exp_t x;
        reset     = r;
        enable    = e;
        tgt_valid = v;
        tgt_in    = 7'(t);
        @(posedge clk);
        n++;
        model_edge(r, e, v, t);
        x.duty  = m_duty;
        x.busy  = m_ramp;
        x.done  = m_done;
        x.clamp = m_clamp;
        x.rdy   = e & r;
        q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1, 1, 0, 0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("duty",      int'(duty),      x.duty);
                chk("busy",      int'(busy),      int'(x.busy));
                chk("done",      int'(done),      int'(x.done));
                chk("clamp_err", int'(clamp_err), int'(x.clamp));
                chk("tgt_ready", int'(tgt_ready), int'(x.rdy));
            end
        end
    end

    initial begin : stim
        reset     = 1'b0;
        enable    = 1'b0;
        tgt_valid = 1'b0;
        tgt_in    = '0;

        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        idle(2);

        // Ramp up 0 -> 20
        drive(1, 1, 1, 20);
        idle(20);

        // Up to full scale, then a short step down that lands on target
        drive(1, 1, 1, 100);
        idle(90);
        drive(1, 1, 1, 97);
        idle(8);
        drive(1, 1, 1, 97);
        idle(3);

        // Over-range target is clamped
        drive(1, 1, 1, 120);
        idle(8);
        drive(1, 1, 1, 0);
        idle(85);

        // Retarget on the same edge as a pending step
        drive(1, 1, 1, 50);
        idle(11);
        drive(1, 1, 1, 10);
        idle(6);

        // Retarget mid-ramp
        drive(1, 1, 1, 50);
        idle(6);
        drive(1, 1, 1, 30);
        idle(30);

        // Freeze mid-ramp with a refused target offered, then reset mid-ramp
        drive(1, 1, 1, 0);
        idle(6);
        for (int i = 0; i < 10; i++) drive(1, 0, 1, 90);
        idle(10);
        drive(0, 1, 0, 0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 200) != 0,
                  ($urandom % 10) != 0,
                  ($urandom % 12) == 0,
                  int'($urandom % 128));
        end

        @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
